// File: rtl/dpram_port_arb_pkg.sv
// dpram_arb_pkg: shared types and constants for the dual-port RAM port arbiter.
//   NUM_REQ   - number of requesters sharing the RAM port
//   AW        - default byte-address width
//   req_id_t  - requester index
//   mem_req_t - one request beat {we, addr, data lanes, byte mask}
package dpram_arb_pkg;
    localparam int NUM_REQ = 2;
    localparam int AW      = 15;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [3:0][7:0] data;
        logic [3:0]      mask;
    } mem_req_t;
endpackage

// File: rtl/dpram_port_arb_if.sv
// dpram_port_arb_if: bundles both requester channels and the RAM port.
//   t_rN_*  request channel of requester N (valid/ready/we/addr/data/mask)
//   i_rN_*  read-response channel of requester N (valid/ready/data)
//   i_m_*   request towards the RAM port, t_m_* RAM ready and read return
// Modports: slave = the arbiter, master = requesters plus RAM.
interface dpram_port_arb_if #(
    parameter int AW = dpram_arb_pkg::AW
) ();
    import dpram_arb_pkg::*;

    logic          t_r0_valid, t_r0_ready, t_r0_we;
    logic [AW-1:0] t_r0_addr;
    logic [31:0]   t_r0_data;
    logic [3:0]    t_r0_mask;
    logic          i_r0_valid, i_r0_ready;
    logic [31:0]   i_r0_data;

    logic          t_r1_valid, t_r1_ready, t_r1_we;
    logic [AW-1:0] t_r1_addr;
    logic [31:0]   t_r1_data;
    logic [3:0]    t_r1_mask;
    logic          i_r1_valid, i_r1_ready;
    logic [31:0]   i_r1_data;

    logic          i_m_valid, t_m_ready, i_m_we;
    logic [AW-1:0] i_m_addr;
    logic [31:0]   i_m_data;
    logic [3:0]    i_m_mask;
    logic          t_m_rvalid;
    logic [31:0]   t_m_rdata;

    modport slave (
        input  t_r0_valid, t_r0_we, t_r0_addr, t_r0_data, t_r0_mask, i_r0_ready,
        input  t_r1_valid, t_r1_we, t_r1_addr, t_r1_data, t_r1_mask, i_r1_ready,
        input  t_m_ready, t_m_rvalid, t_m_rdata,
        output t_r0_ready, i_r0_valid, i_r0_data,
        output t_r1_ready, i_r1_valid, i_r1_data,
        output i_m_valid, i_m_we, i_m_addr, i_m_data, i_m_mask
    );

    modport master (
        output t_r0_valid, t_r0_we, t_r0_addr, t_r0_data, t_r0_mask, i_r0_ready,
        output t_r1_valid, t_r1_we, t_r1_addr, t_r1_data, t_r1_mask, i_r1_ready,
        output t_m_ready, t_m_rvalid, t_m_rdata,
        input  t_r0_ready, i_r0_valid, i_r0_data,
        input  t_r1_ready, i_r1_valid, i_r1_data,
        input  i_m_valid, i_m_we, i_m_addr, i_m_data, i_m_mask
    );
endinterface

// File: rtl/dpram_port_arb_resp_fifo.sv
// resp_fifo: synchronous circular FIFO holding read responses for one requester.
//   i_push/i_push_data  write side (data visible at the head one cycle later)
//   i_pop               consume head entry (ignored when empty)
//   o_pop_data          head entry, o_empty, o_count occupancy
// Push and pop together are allowed at any occupancy, including full.
module resp_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop & (r_count != '0);
    // When full, a same-cycle pop frees the slot being overwritten.
    assign w_push = i_push & ((r_count != CW'(DEPTH)) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
endmodule

// File: rtl/dpram_port_arb.sv
// dpram_port_arb: round-robin share of one RAM port between two requesters.
//   clk, rstf  clock and asynchronous active-high reset
//   bus        dpram_port_arb_if.slave: requester channels, RAM port
// Grant is combinational. Reads are only issued when the requester has a
// free response slot (FIFO entries + the read in flight), so the
// unstallable RAM return always has room. AW must match the package AW.
module dpram_port_arb #(
    parameter int AW         = dpram_arb_pkg::AW,
    parameter int RESP_DEPTH = 2
) (
    input logic             clk,
    input logic             rstf,
    dpram_port_arb_if.slave bus
);
    import dpram_arb_pkg::*;

    localparam int CW = $clog2(RESP_DEPTH + 1);

    mem_req_t             w_req [NUM_REQ];
    mem_req_t             w_win;
    logic [NUM_REQ-1:0]   w_valid, w_rready, w_elig, w_grant, w_inflight;
    logic [NUM_REQ-1:0]   w_push, w_pop, w_empty;
    logic [31:0]          w_rdata [NUM_REQ];
    logic [CW-1:0]        w_count [NUM_REQ];
    req_id_t              w_win_id;
    logic                 w_hs;

    req_id_t              r_pri;
    logic                 r_pend_valid;
    req_id_t              r_pend_id;

    assign w_req[0] = {bus.t_r0_we, bus.t_r0_addr, bus.t_r0_data, bus.t_r0_mask};
    assign w_req[1] = {bus.t_r1_we, bus.t_r1_addr, bus.t_r1_data, bus.t_r1_mask};
    assign w_valid  = {bus.t_r1_valid, bus.t_r0_valid};
    assign w_rready = {bus.i_r1_ready, bus.i_r0_ready};

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_req
        logic [CW:0] w_used;

        assign w_inflight[n] = r_pend_valid & (r_pend_id == req_id_t'(n));
        assign w_used        = {1'b0, w_count[n]} + (CW+1)'(w_inflight[n]);
        // Writes never need a response slot; reset masks all requests.
        assign w_elig[n]     = ~rstf & w_valid[n] &
                               (w_req[n].we | (w_used < (CW+1)'(RESP_DEPTH)));
        assign w_push[n]     = bus.t_m_rvalid & w_inflight[n];
        assign w_pop[n]      = ~w_empty[n] & w_rready[n];

        resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(32)) u_fifo (
            .clk        (clk),
            .rst        (rstf),
            .i_push     (w_push[n]),
            .i_push_data(bus.t_m_rdata),
            .i_pop      (w_pop[n]),
            .o_pop_data (w_rdata[n]),
            .o_empty    (w_empty[n]),
            .o_count    (w_count[n])
        );

        a_no_overflow: assert property (@(posedge clk) disable iff (rstf)
            w_used <= (CW+1)'(RESP_DEPTH));
    end

    // r_pri only breaks ties; a lone eligible requester always wins.
    assign w_grant[0] = w_elig[0] & (~w_elig[1] | (r_pri == 1'b0));
    assign w_grant[1] = w_elig[1] & (~w_elig[0] | (r_pri == 1'b1));
    assign w_win_id   = w_grant[1];
    assign w_hs       = (|w_elig) & bus.t_m_ready;

    always_comb begin
        w_win = '0;
        if (w_grant[0])      w_win = w_req[0];
        else if (w_grant[1]) w_win = w_req[1];
    end

    assign bus.i_m_valid  = |w_elig;
    assign bus.i_m_we     = w_win.we;
    assign bus.i_m_addr   = w_win.addr;
    assign bus.i_m_data   = w_win.data;
    assign bus.i_m_mask   = w_win.mask;
    assign bus.t_r0_ready = w_grant[0] & bus.t_m_ready;
    assign bus.t_r1_ready = w_grant[1] & bus.t_m_ready;
    assign bus.i_r0_valid = ~w_empty[0];
    assign bus.i_r1_valid = ~w_empty[1];
    assign bus.i_r0_data  = w_rdata[0];
    assign bus.i_r1_data  = w_rdata[1];

    always_ff @(posedge clk or posedge rstf) begin
        if (rstf) begin
            r_pri        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
        end else begin
            if (w_hs) begin
                r_pri     <= ~w_win_id;
                r_pend_id <= w_win_id;
            end
            r_pend_valid <= w_hs & ~w_win.we;
        end
    end

    // A return with nothing in flight is dropped (e.g. across a reset).
    a_rvalid_tracked: assert property (@(posedge clk) disable iff (rstf)
        bus.t_m_rvalid |-> r_pend_valid);
endmodule
